// File: rtl/seven_segment_decoder.sv
`default_nettype none
// ============================================================================
// Module      : seven_segment_decoder
// Description : Registered BCD/hex to seven-segment decoder with lamp test,
//               blanking, ripple-blank chaining and selectable drive polarity.
//               Define SEVEN_SEG_HEX_EN to decode num 10-15 as A,b,C,d,E,F.
// Revision    : 1.0 - initial release
// ============================================================================
module seven_segment_decoder #(
  parameter int ACTIVE_LOW = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] num,
  input  logic       in_valid,
  input  logic       lt,
  input  logic       bl,
  input  logic       rbi,
  input  logic       dp_in,
  output logic [6:0] seg,
  output logic       dp,
  output logic       rbo,
  output logic       out_valid
);

  localparam logic       c_inv     = (ACTIVE_LOW != 0);
  localparam logic [6:0] c_all_off = 7'b0000000;
  localparam logic [6:0] c_all_on  = 7'b1111111;

  logic [6:0] w_glyph;
  logic [6:0] w_seg;
  logic       w_dp;
  logic       w_rbo;

  logic [6:0] r_seg;
  logic       r_dp;
  logic       r_rbo;
  logic       r_out_valid;

  // Glyph table in logical polarity, bits g..a
  always_comb begin
    w_glyph = c_all_off;
    case (num)
      4'd0:  w_glyph = 7'b0111111;
      4'd1:  w_glyph = 7'b0000110;
      4'd2:  w_glyph = 7'b1011011;
      4'd3:  w_glyph = 7'b1001111;
      4'd4:  w_glyph = 7'b1100110;
      4'd5:  w_glyph = 7'b1101101;
      4'd6:  w_glyph = 7'b1111101;
      4'd7:  w_glyph = 7'b0000111;
      4'd8:  w_glyph = 7'b1111111;
      4'd9:  w_glyph = 7'b1101111;
`ifdef SEVEN_SEG_HEX_EN
      4'd10: w_glyph = 7'b1110111;
      4'd11: w_glyph = 7'b1111100;
      4'd12: w_glyph = 7'b0111001;
      4'd13: w_glyph = 7'b1011110;
      4'd14: w_glyph = 7'b1111001;
      4'd15: w_glyph = 7'b1110001;
`endif
      default: w_glyph = c_all_off;
    endcase
  end

  // Lamp test overrides blanking, which overrides ripple blank
  always_comb begin
    w_seg = w_glyph;
    w_dp  = dp_in;
    w_rbo = 1'b0;
    if (lt) begin
      w_seg = c_all_on;
      w_dp  = 1'b1;
    end else if (bl) begin
      w_seg = c_all_off;
      w_dp  = 1'b0;
    end else if (rbi && (num == 4'd0)) begin
      w_seg = c_all_off;
      w_rbo = 1'b1;
    end
  end

  // Polarity is folded in before the register so outputs come straight off flops
  always_ff @(posedge clk) begin
    if (rst) begin
      r_seg       <= {7{c_inv}};
      r_dp        <= c_inv;
      r_rbo       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_seg <= w_seg ^ {7{c_inv}};
        r_dp  <= w_dp ^ c_inv;
        r_rbo <= w_rbo;
      end
    end
  end

  assign seg       = r_seg;
  assign dp        = r_dp;
  assign rbo       = r_rbo;
  assign out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_seven_segment_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_seven_segment_decoder
// Description : Directed bench for seven_segment_decoder, active-high and
//               active-low instances side by side. Honours SEVEN_SEG_HEX_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seven_segment_decoder;

  logic       clk;
  logic       rst;
  logic [3:0] num;
  logic       in_valid;
  logic       lt;
  logic       bl;
  logic       rbi;
  logic       dp_in;

  logic [6:0] seg_h;
  logic       dp_h;
  logic       rbo_h;
  logic       ov_h;
  logic [6:0] seg_l;
  logic       dp_l;
  logic       rbo_l;
  logic       ov_l;

  int errors = 0;
  int checks = 0;

  logic [6:0] c_digits [10];

`ifdef SEVEN_SEG_HEX_EN
  localparam logic [6:0] c_exp_11 = 7'b1111100;
`else
  localparam logic [6:0] c_exp_11 = 7'b0000000;
`endif

  seven_segment_decoder #(.ACTIVE_LOW(0)) u_dut_h (
    .clk(clk), .rst(rst), .num(num), .in_valid(in_valid), .lt(lt), .bl(bl),
    .rbi(rbi), .dp_in(dp_in), .seg(seg_h), .dp(dp_h), .rbo(rbo_h), .out_valid(ov_h)
  );

  seven_segment_decoder #(.ACTIVE_LOW(1)) u_dut_l (
    .clk(clk), .rst(rst), .num(num), .in_valid(in_valid), .lt(lt), .bl(bl),
    .rbi(rbi), .dp_in(dp_in), .seg(seg_l), .dp(dp_l), .rbo(rbo_l), .out_valid(ov_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, then sample 1 ns after the rising edge
  task automatic step(input logic v, input logic [3:0] n, input logic t_lt,
                      input logic t_bl, input logic t_rbi, input logic t_dp);
    @(negedge clk);
    in_valid = v; num = n; lt = t_lt; bl = t_bl; rbi = t_rbi; dp_in = t_dp;
    @(posedge clk);
    #1;
  endtask

  initial begin
    c_digits[0] = 7'b0111111; c_digits[1] = 7'b0000110;
    c_digits[2] = 7'b1011011; c_digits[3] = 7'b1001111;
    c_digits[4] = 7'b1100110; c_digits[5] = 7'b1101101;
    c_digits[6] = 7'b1111101; c_digits[7] = 7'b0000111;
    c_digits[8] = 7'b1111111; c_digits[9] = 7'b1101111;

    rst = 1'b1; in_valid = 1'b0; num = 4'd0; lt = 1'b0; bl = 1'b0; rbi = 1'b0; dp_in = 1'b0;

    // Input presented during reset must be discarded
    step(1'b1, 4'd8, 1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 4'd8, 1'b1, 1'b0, 1'b0, 1'b1);
    check("rst_seg_h", {1'b0, seg_h}, 8'h00);
    check("rst_dp_h",  {7'd0, dp_h},  8'h00);
    check("rst_rbo_h", {7'd0, rbo_h}, 8'h00);
    check("rst_ov_h",  {7'd0, ov_h},  8'h00);
    check("rst_seg_l", {1'b0, seg_l}, 8'h7F);
    check("rst_dp_l",  {7'd0, dp_l},  8'h01);
    check("rst_ov_l",  {7'd0, ov_l},  8'h00);

    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 4'(i), 1'b0, 1'b0, 1'b0, 1'b0);
      check($sformatf("dig%0d_seg", i), {1'b0, seg_h}, {1'b0, c_digits[i]});
      check($sformatf("dig%0d_ov", i),  {7'd0, ov_h},  8'h01);
      check($sformatf("dig%0d_seg_l", i), {1'b0, seg_l}, {1'b0, ~c_digits[i]});
    end

    step(1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("rbz_seg", {1'b0, seg_h}, 8'h00);
    check("rbz_dp",  {7'd0, dp_h},  8'h01);
    check("rbz_rbo", {7'd0, rbo_h}, 8'h01);
    check("rbz_rbo_l", {7'd0, rbo_l}, 8'h01);

    // rbo holds along with seg while in_valid is low
    step(1'b0, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    check("rbz_hold_rbo", {7'd0, rbo_h}, 8'h01);
    check("rbz_hold_ov",  {7'd0, ov_h},  8'h00);

    step(1'b1, 4'd5, 1'b0, 1'b0, 1'b1, 1'b1);
    check("rb5_seg", {1'b0, seg_h}, 8'h6D);
    check("rb5_dp",  {7'd0, dp_h},  8'h01);
    check("rb5_rbo", {7'd0, rbo_h}, 8'h00);

    step(1'b1, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    check("lt_seg", {1'b0, seg_h}, 8'h7F);
    check("lt_dp",  {7'd0, dp_h},  8'h01);
    check("lt_seg_l", {1'b0, seg_l}, 8'h00);

    step(1'b1, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    check("lt_rbi_rbo", {7'd0, rbo_h}, 8'h00);
    check("lt_rbi_seg", {1'b0, seg_h}, 8'h7F);

    step(1'b1, 4'd3, 1'b0, 1'b1, 1'b0, 1'b1);
    check("bl_seg", {1'b0, seg_h}, 8'h00);
    check("bl_dp",  {7'd0, dp_h},  8'h00);
    check("bl_dp_l", {7'd0, dp_l}, 8'h01);

    step(1'b1, 4'd11, 1'b0, 1'b0, 1'b0, 1'b1);
    check("n11_seg", {1'b0, seg_h}, {1'b0, c_exp_11});
    check("n11_dp",  {7'd0, dp_h},  8'h01);
    check("n11_rbo", {7'd0, rbo_h}, 8'h00);

    // rbi must not affect non-zero codes, including hex range
    step(1'b1, 4'd15, 1'b0, 1'b0, 1'b1, 1'b0);
`ifdef SEVEN_SEG_HEX_EN
    check("n15_seg", {1'b0, seg_h}, 8'h71);
`else
    check("n15_seg", {1'b0, seg_h}, 8'h00);
`endif
    check("n15_rbo", {7'd0, rbo_h}, 8'h00);

    step(1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("al1_seg_l", {1'b0, seg_l}, 8'h79);
    check("al1_dp_l",  {7'd0, dp_l},  8'h01);
    check("al1_ov_l",  {7'd0, ov_l},  8'h01);

    step(1'b1, 4'd7, 1'b0, 1'b0, 1'b0, 1'b1);
    check("n7_seg", {1'b0, seg_h}, 8'h07);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0);
      check($sformatf("hold%0d_seg", i), {1'b0, seg_h}, 8'h07);
      check($sformatf("hold%0d_dp", i),  {7'd0, dp_h},  8'h01);
      check($sformatf("hold%0d_ov", i),  {7'd0, ov_h},  8'h00);
    end

    // Reset mid-stream with a valid input on the same edge
    rst = 1'b1;
    step(1'b1, 4'd8, 1'b0, 1'b0, 1'b0, 1'b1);
    check("mrst_seg_l", {1'b0, seg_l}, 8'h7F);
    check("mrst_ov_l",  {7'd0, ov_l},  8'h00);
    check("mrst_seg_h", {1'b0, seg_h}, 8'h00);
    check("mrst_dp_h",  {7'd0, dp_h},  8'h00);

    rst = 1'b0;
    step(1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    check("post_seg", {1'b0, seg_h}, 8'h4F);
    check("post_ov",  {7'd0, ov_h},  8'h01);
    step(1'b0, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    check("post_ov_drop", {7'd0, ov_h}, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
